// File: rtl/hash_sched_if.sv
// -----------------------------------------------------------------------------
// hash_sched_if
//   Bundles every hash_sched signal except clk/rst: the per-requester request
//   bus, the beat/clear channel to the Toeplitz accumulator, the returned
//   accumulator value, the valid/ready response channel and the busy flag.
//
//   Parameters
//     NUM_REQ   : number of requesters (1..16)
//     MAX_BYTES : longest key in bytes (no larger than the accumulator width, 36)
//     LEN_W     : width of one length field
//     ID_W      : width of the response requester index
//
//   Modports
//     master : the scheduler side (drives req_ready, hash_*, resp_*, busy)
//     slave  : the surrounding logic (requesters, accumulator, consumer)
// -----------------------------------------------------------------------------
interface hash_sched_if #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BYTES = 12,
   parameter int LEN_W     = $clog2(MAX_BYTES + 1),
   parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
   // request side, one lane per requester
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ*MAX_BYTES*8-1:0] req_data;
   logic [NUM_REQ*LEN_W-1:0]       req_len;

   // accumulator side
   logic [31:0]                    hash_data;
   logic [1:0]                     hash_data_len;
   logic                           hash_data_valid;
   logic                           hash_clear;
   logic [31:0]                    hash_out;

   // response side
   logic                           resp_valid;
   logic                           resp_ready;
   logic [31:0]                    resp_hash;
   logic [ID_W-1:0]                resp_id;

   logic                           busy;

   modport master (
      input  req_valid, req_data, req_len, hash_out, resp_ready,
      output req_ready, hash_data, hash_data_len, hash_data_valid, hash_clear,
             resp_valid, resp_hash, resp_id, busy
   );

   modport slave (
      output req_valid, req_data, req_len, hash_out, resp_ready,
      input  req_ready, hash_data, hash_data_len, hash_data_valid, hash_clear,
             resp_valid, resp_hash, resp_id, busy
   );
endinterface

// File: rtl/hash_sched.sv
// -----------------------------------------------------------------------------
// hash_sched
//   Shares one Toeplitz hash accumulator between NUM_REQ requesters. One
//   request is granted at a time: the accumulator is cleared, the key is
//   streamed in 4/2/1-byte beats, the resulting 32-bit hash is captured and
//   returned with the requester index on a valid/ready response channel.
//
//   Ports
//     clk  : clock
//     rst  : synchronous, active-high reset (the accumulator shares it)
//     bus  : hash_sched_if.master
//              req_valid/req_ready/req_data/req_len : request lanes
//              hash_data/hash_data_len/hash_data_valid/hash_clear : beats out
//              hash_out  : accumulator value (combinational from its state)
//              resp_valid/resp_ready/resp_hash/resp_id : response channel
//              busy      : high whenever the sequencer is not idle
//
//   Configuration
//     HASH_SCHED_STRICT_PRIO_EN : when defined, fixed priority (lowest index
//                                 wins); otherwise round-robin starting at a
//                                 pointer that moves past each granted index.
// -----------------------------------------------------------------------------
module hash_sched #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BYTES = 12,
   parameter int LEN_W     = $clog2(MAX_BYTES + 1),
   parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic         clk,
   input  logic         rst,
   hash_sched_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len_q;      // clamped key length of the granted request
   logic [LEN_W-1:0] off_q;      // byte offset of the next beat
   logic [ID_W-1:0]  id_q;
   logic [31:0]      hash_q;
   logic [7:0]       data_q [MAX_BYTES];

   logic             grant_any;
   logic [ID_W-1:0]  grant_idx;
   logic             accept;
   logic [LEN_W-1:0] sel_len;
   logic [LEN_W-1:0] clamp_len;

   int               rem;
   int               beat_bytes;
   logic             last_beat;

`ifndef HASH_SCHED_STRICT_PRIO_EN
   logic [ID_W-1:0]  ptr_q;      // first index searched by the round-robin
`endif

   // ---------------------------------------------------------------------------
   // Arbitration. The loops run downward so the candidate searched first is the
   // last one written and therefore wins.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it holding its old value and no latch is inferred.
      grant_any = 1'b0;
      grant_idx = '0;
`ifdef HASH_SCHED_STRICT_PRIO_EN
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i]) begin
            grant_any = 1'b1;
            grant_idx = ID_W'(i);
         end
      end
`else
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         logic [ID_W-1:0] cand;
         cand = ID_W'((int'(ptr_q) + j) % NUM_REQ);
         if (bus.req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
`endif
   end

   // The grant is only offered in IDLE; a granted lane is valid by construction,
   // so offering it is the same as accepting it.
   assign accept = (state == S_IDLE) && grant_any;

   always_comb begin
      bus.req_ready = '0;
      if (accept) bus.req_ready[grant_idx] = 1'b1;
   end

   // Over-long keys are truncated to what the buffer holds.
   assign sel_len   = bus.req_len[int'(grant_idx)*LEN_W +: LEN_W];
   assign clamp_len = (sel_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : sel_len;

   // ---------------------------------------------------------------------------
   // Beat sizing: 4 bytes while at least 4 remain, otherwise the largest of 2/1
   // that fits, which turns a 3-byte tail into 2 + 1.
   // ---------------------------------------------------------------------------
   always_comb begin
      rem = int'(len_q) - int'(off_q);
      if (rem >= 4)      beat_bytes = 4;
      else if (rem >= 2) beat_bytes = 2;
      else               beat_bytes = 1;
      last_beat = (rem <= beat_bytes);
   end

   always_comb begin
      bus.hash_data = '0;
      if (state == S_FEED) begin
         for (int k = 0; k < 4; k++) begin
            if (k < beat_bytes && (int'(off_q) + k) < MAX_BYTES)
               bus.hash_data[k*8 +: 8] = data_q[int'(off_q) + k];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and per-state strobes.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt           = state;
      bus.hash_clear      = 1'b0;
      bus.hash_data_valid = 1'b0;
      bus.hash_data_len   = 2'd0;
      bus.resp_valid      = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            bus.hash_clear = 1'b1;
            state_nxt      = (len_q == '0) ? S_WAIT : S_FEED;
         end
         S_FEED: begin
            bus.hash_data_valid = 1'b1;
            // A 4-byte beat is encoded as 0 on the accumulator interface.
            bus.hash_data_len   = (beat_bytes == 4) ? 2'd0 : 2'(beat_bytes);
            if (last_beat) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // Gives the accumulator one edge to absorb the final beat.
            state_nxt = S_RESP;
         end
         S_RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.busy      = (state != S_IDLE);
   assign bus.resp_hash = (state == S_RESP) ? hash_q : '0;
   assign bus.resp_id   = (state == S_RESP) ? id_q   : '0;

   // ---------------------------------------------------------------------------
   // State and control registers.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments, so every register samples the values
      // from before this edge regardless of statement order.
      if (rst) begin
         state  <= S_IDLE;
         len_q  <= '0;
         off_q  <= '0;
         id_q   <= '0;
         hash_q <= '0;
`ifndef HASH_SCHED_STRICT_PRIO_EN
         ptr_q  <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            len_q <= clamp_len;
            id_q  <= grant_idx;
`ifndef HASH_SCHED_STRICT_PRIO_EN
            ptr_q <= ID_W'((int'(grant_idx) + 1) % NUM_REQ);
`endif
         end
         if (state == S_CLEAR) off_q <= '0;
         if (state == S_FEED)  off_q <= off_q + LEN_W'(beat_bytes);
         if (state == S_WAIT)  hash_q <= bus.hash_out;
      end
   end

   // NOTE: the key buffer has no reset; it is written on every accept before
   // any byte of it is read, so a reset would only cost flops.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < MAX_BYTES; k++)
            data_q[k] <= bus.req_data[(int'(grant_idx)*MAX_BYTES + k)*8 +: 8];
      end
   end

endmodule
